// File: rtl/bitserial_nn_if.sv
// Stream-in / weight-write / stream-out bundle for the bit-serial NN engine.
// The master modport is the environment's view, slave is the engine's view.
interface bitserial_nn_if #(
  parameter int DATA_W   = 16,
  parameter int N_IN     = 256,
  parameter int N_HIDDEN = 128,
  parameter int N_LAYERS = 3
);
  localparam int ACC_W = 2*DATA_W + $clog2((N_IN > 2) ? N_IN : 2);
  localparam int IW    = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int HW    = (N_HIDDEN > 1) ? $clog2(N_HIDDEN) : 1;
  localparam int LW    = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;

  logic signed [DATA_W-1:0] s_axis_tdata;
  logic                     s_axis_tvalid;
  logic                     s_axis_tready;
  logic                     s_axis_tlast;
  logic                     w_wr_en;
  logic [HW-1:0]            w_addr_h;
  logic [IW-1:0]            w_addr_i;
  logic [LW-1:0]            w_addr_l;
  logic signed [DATA_W-1:0] w_data;
  logic signed [ACC_W-1:0]  m_axis_tdata;
  logic                     m_axis_tvalid;
  logic                     m_axis_tready;
  logic                     m_axis_tlast;
  logic                     busy;

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output w_wr_en, w_addr_h, w_addr_i, w_addr_l, w_data,
    output m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, busy
  );

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  w_wr_en, w_addr_h, w_addr_i, w_addr_l, w_data,
    input  m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, busy
  );
endinterface

// File: rtl/bitserial_nn.sv
// Fully-connected ReLU network evaluated by P bit-serial MAC lanes; weights live
// in per-lane RAMs (lane = h % P) so every lane fetches its weight in parallel.
module bitserial_nn #(
  parameter int DATA_W    = 16,
  parameter int PRECISION = 16,
  parameter int N_IN      = 256,
  parameter int N_HIDDEN  = 128,
  parameter int N_LAYERS  = 3,
  parameter int P         = 4
) (
  input logic           clk,
  input logic           rst,
  bitserial_nn_if.slave bus
);
  localparam int ACC_W = 2*DATA_W + $clog2((N_IN > 2) ? N_IN : 2);
  localparam int G     = N_HIDDEN / P;
  localparam int DEPTH = N_LAYERS * G * N_IN;
  localparam int IW    = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int HW    = (N_HIDDEN > 1) ? $clog2(N_HIDDEN) : 1;
  localparam int LW    = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
  localparam int GW    = (G > 1) ? $clog2(G) : 1;
  localparam int BW    = (PRECISION > 1) ? $clog2(PRECISION) : 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, OUTPUT} state_t;

  function automatic logic signed [DATA_W-1:0] relu_trunc(input logic signed [ACC_W-1:0] a);
    return a[ACC_W-1] ? '0 : $signed(a[DATA_W-1:0]);
  endfunction

  // Weight bit b contributes x*2^b, except the top bit which carries weight -2^b.
  function automatic logic signed [ACC_W-1:0] bit_term(input logic signed [DATA_W-1:0] x,
                                                        input logic wbit, input logic [BW-1:0] b);
    logic signed [ACC_W-1:0] sh;
    sh = ACC_W'(x) <<< b;
    if (!wbit) return '0;
    return (int'(b) == PRECISION-1) ? -sh : sh;
  endfunction

  state_t                   state;
  logic signed [DATA_W-1:0] wram   [P][DEPTH];
  logic signed [DATA_W-1:0] in_buf [N_IN];
  logic signed [DATA_W-1:0] hid    [2][N_HIDDEN];
  logic signed [ACC_W-1:0]  term_p0 [P];
  logic signed [ACC_W-1:0]  acc_p1  [P];
  logic signed [ACC_W-1:0]  sum_p1  [P];
  logic [IW-1:0]            ld_idx, idx;
  logic [LW-1:0]            layer;
  logic [GW-1:0]            grp, grp_p0;
  logic [BW-1:0]            bitc;
  logic [HW-1:0]            out_idx;
  logic                     wsel, wsel_p0, drain, vld_p0, first_p0, last_p0;
  logic                     s_ready_r, m_valid_r, m_last_r, busy_r;
  logic signed [ACC_W-1:0]  m_data_r;
  logic                     accept, wr_ok, unused_tlast;
  logic [AW-1:0]            wr_addr, rd_addr;
  logic signed [DATA_W-1:0] act_cur;

  // tlast is informational only; the element count ends the input vector.
  assign unused_tlast = bus.s_axis_tlast;

  assign accept  = bus.s_axis_tvalid && s_ready_r;
  assign wr_ok   = bus.w_wr_en && !busy_r && (int'(bus.w_addr_l) < N_LAYERS) &&
                   (int'(bus.w_addr_h) < N_HIDDEN) && (int'(bus.w_addr_i) < N_IN);
  assign wr_addr = AW'((int'(bus.w_addr_l) * G + int'(bus.w_addr_h) / P) * N_IN + int'(bus.w_addr_i));
  assign rd_addr = AW'((int'(layer) * G + int'(grp)) * N_IN + int'(idx));

  // Layers past the first read the other ping-pong half, zero-padded beyond N_HIDDEN.
  always_comb begin
    act_cur = '0;
    if (layer == '0) act_cur = in_buf[idx];
    else if (int'(idx) < N_HIDDEN) act_cur = hid[~wsel][HW'(idx)];
  end

  always_comb
    for (int k = 0; k < P; k++)
      sum_p1[k] = (first_p0 ? ACC_W'(0) : acc_p1[k]) + term_p0[k];

  always_ff @(posedge clk) begin
    if (wr_ok)
      for (int k = 0; k < P; k++)
        if (int'(bus.w_addr_h) % P == k) wram[k][wr_addr] <= bus.w_data;
    if (accept) in_buf[ld_idx] <= bus.s_axis_tdata;
    // p0: per-lane partial product for the current weight bit
    for (int k = 0; k < P; k++)
      term_p0[k] <= bit_term(act_cur, wram[k][rd_addr][bitc], bitc);
    // p1: accumulate; the final bit of a neuron retires its activation
    if (vld_p0)
      for (int k = 0; k < P; k++) begin
        acc_p1[k] <= sum_p1[k];
        if (last_p0) hid[wsel_p0][HW'(int'(grp_p0) * P + k)] <= relu_trunc(sum_p1[k]);
      end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      s_ready_r <= 1'b0;
      m_valid_r <= 1'b0;
      m_last_r  <= 1'b0;
      m_data_r  <= '0;
      busy_r    <= 1'b0;
      ld_idx    <= '0;
      idx       <= '0;
      layer     <= '0;
      grp       <= '0;
      bitc      <= '0;
      out_idx   <= '0;
      wsel      <= 1'b0;
      wsel_p0   <= 1'b0;
      drain     <= 1'b0;
      vld_p0    <= 1'b0;
      first_p0  <= 1'b0;
      last_p0   <= 1'b0;
      grp_p0    <= '0;
    end else begin
      vld_p0 <= 1'b0;
      case (state)
        IDLE, LOAD: begin
          s_ready_r <= 1'b1;
          if (accept) begin
            busy_r <= 1'b1;
            state  <= LOAD;
            ld_idx <= ld_idx + 1'b1;
            if (int'(ld_idx) == N_IN-1) begin
              s_ready_r <= 1'b0;
              state     <= COMPUTE;
              ld_idx    <= '0;
              layer     <= '0;
              grp       <= '0;
              idx       <= '0;
              bitc      <= '0;
              wsel      <= 1'b0;
              drain     <= 1'b0;
            end
          end
        end
        COMPUTE: begin
          if (!drain) begin
            vld_p0   <= 1'b1;
            first_p0 <= (idx == '0) && (bitc == '0);
            last_p0  <= (int'(idx) == N_IN-1) && (int'(bitc) == PRECISION-1);
            grp_p0   <= grp;
            wsel_p0  <= wsel;
            bitc     <= bitc + 1'b1;
            if (int'(bitc) == PRECISION-1) begin
              bitc <= '0;
              idx  <= idx + 1'b1;
              if (int'(idx) == N_IN-1) begin
                idx <= '0;
                grp <= grp + 1'b1;
                if (int'(grp) == G-1) begin
                  grp   <= '0;
                  drain <= 1'b1;
                end
              end
            end
          end else if (!vld_p0) begin
            // Pipeline empty: the layer's last group is now in the buffer.
            drain <= 1'b0;
            if (int'(layer) == N_LAYERS-1) begin
              state     <= OUTPUT;
              m_valid_r <= 1'b1;
              m_data_r  <= ACC_W'(hid[wsel][0]);
              m_last_r  <= (N_HIDDEN == 1);
              out_idx   <= '0;
            end else begin
              layer <= layer + 1'b1;
              wsel  <= ~wsel;
            end
          end
        end
        OUTPUT: begin
          if (bus.m_axis_tready) begin
            if (m_last_r) begin
              m_valid_r <= 1'b0;
              m_last_r  <= 1'b0;
              busy_r    <= 1'b0;
              s_ready_r <= 1'b1;
              state     <= IDLE;
            end else begin
              out_idx  <= out_idx + 1'b1;
              m_data_r <= ACC_W'(hid[wsel][out_idx + 1'b1]);
              m_last_r <= (int'(out_idx) == N_HIDDEN-2);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.s_axis_tready = s_ready_r;
  assign bus.m_axis_tvalid = m_valid_r;
  assign bus.m_axis_tlast  = m_last_r;
  assign bus.m_axis_tdata  = m_data_r;
  assign bus.busy          = busy_r;
endmodule

// File: tb/tb_bitserial_nn.sv
// Directed bench: a 4x4 single-layer instance for hand-computed vectors and a
// 16-in/8-neuron/3-layer instance checked against an arithmetic reference.
module tb_bitserial_nn;
  logic clk = 1'b0;
  logic rst_s = 1'b1;
  logic rst_m = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bitserial_nn_if #(.DATA_W(16), .N_IN(4), .N_HIDDEN(4), .N_LAYERS(1)) sb ();
  bitserial_nn_if #(.DATA_W(16), .N_IN(16), .N_HIDDEN(8), .N_LAYERS(3)) mb ();

  bitserial_nn #(.DATA_W(16), .PRECISION(16), .N_IN(4), .N_HIDDEN(4), .N_LAYERS(1), .P(2))
    dut_s (.clk(clk), .rst(rst_s), .bus(sb));
  bitserial_nn #(.DATA_W(16), .PRECISION(16), .N_IN(16), .N_HIDDEN(8), .N_LAYERS(3), .P(4))
    dut_m (.clk(clk), .rst(rst_m), .bus(mb));

  int                vec_s [4];
  logic signed [33:0] got_s [4];
  logic               last_s[4];
  int                 nrecv_s;

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_s(input int l, input int h, input int i, input int d);
    sb.w_wr_en  = 1'b1;
    sb.w_addr_l = 1'(l);
    sb.w_addr_h = 2'(h);
    sb.w_addr_i = 2'(i);
    sb.w_data   = 16'(d);
    clk_step();
    sb.w_wr_en  = 1'b0;
  endtask

  task automatic send_s(input bit gaps, output bit timeout);
    int n;
    bit ok;
    n = 0;
    timeout = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (gaps && (k % 2 == 1)) begin
        sb.s_axis_tvalid = 1'b0;
        clk_step();
        clk_step();
      end
      sb.s_axis_tvalid = 1'b1;
      sb.s_axis_tdata  = 16'(vec_s[k]);
      sb.s_axis_tlast  = (k == 3);
      ok = 1'b0;
      while (!ok && n < 50) begin
        ok = sb.s_axis_tready;
        clk_step();
        n++;
      end
      if (!ok) timeout = 1'b1;
    end
    sb.s_axis_tvalid = 1'b0;
    sb.s_axis_tlast  = 1'b0;
  endtask

  task automatic recv_s(input bit bp, output bit timeout, output int stall_err);
    int cyc;
    bit prev_stall, phase;
    logic signed [33:0] prev_d;
    cyc = 0; prev_stall = 1'b0; phase = 1'b0; prev_d = '0;
    nrecv_s = 0; stall_err = 0;
    while (nrecv_s < 4 && cyc < 1000) begin
      sb.m_axis_tready = bp ? phase : 1'b1;
      phase = ~phase;
      if (prev_stall && (!sb.m_axis_tvalid || sb.m_axis_tdata !== prev_d)) stall_err++;
      if (sb.m_axis_tvalid && sb.m_axis_tready) begin
        got_s[nrecv_s]  = sb.m_axis_tdata;
        last_s[nrecv_s] = sb.m_axis_tlast;
        nrecv_s++;
      end
      prev_stall = sb.m_axis_tvalid && !sb.m_axis_tready;
      prev_d = sb.m_axis_tdata;
      clk_step();
      cyc++;
    end
    sb.m_axis_tready = 1'b0;
    timeout = (nrecv_s < 4);
  endtask

  task automatic test_reset();
    sb.s_axis_tvalid = 0; sb.s_axis_tdata = '0; sb.s_axis_tlast = 0; sb.m_axis_tready = 0;
    sb.w_wr_en = 0; sb.w_addr_l = '0; sb.w_addr_h = '0; sb.w_addr_i = '0; sb.w_data = '0;
    mb.s_axis_tvalid = 0; mb.s_axis_tdata = '0; mb.s_axis_tlast = 0; mb.m_axis_tready = 0;
    mb.w_wr_en = 0; mb.w_addr_l = '0; mb.w_addr_h = '0; mb.w_addr_i = '0; mb.w_data = '0;
    rst_s = 1'b1; rst_m = 1'b1;
    clk_step(); clk_step();
    checks++; if (sb.s_axis_tready !== 1'b0) begin failures++; $display("FAIL reset_tready got=%b exp=0", sb.s_axis_tready); end
    checks++; if (sb.m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b exp=0", sb.m_axis_tvalid); end
    checks++; if (sb.m_axis_tlast !== 1'b0) begin failures++; $display("FAIL reset_tlast got=%b exp=0", sb.m_axis_tlast); end
    checks++; if (sb.m_axis_tdata !== 34'sd0) begin failures++; $display("FAIL reset_tdata got=%0d exp=0", sb.m_axis_tdata); end
    checks++; if (sb.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", sb.busy); end
    checks++; if (mb.m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL reset_m_tvalid got=%b exp=0", mb.m_axis_tvalid); end
    rst_s = 1'b0; rst_m = 1'b0;
    clk_step(); clk_step();
    checks++; if (sb.s_axis_tready !== 1'b1) begin failures++; $display("FAIL idle_tready got=%b exp=1", sb.s_axis_tready); end
    checks++; if (mb.s_axis_tready !== 1'b1) begin failures++; $display("FAIL idle_m_tready got=%b exp=1", mb.s_axis_tready); end
  endtask

  task automatic test_all_ones();
    bit to_in, to_out;
    int se;
    for (int h = 0; h < 4; h++) for (int i = 0; i < 4; i++) wr_s(0, h, i, 1);
    vec_s = '{1, 2, 3, 4};
    send_s(1'b0, to_in);
    recv_s(1'b0, to_out, se);
    checks++; if (to_in || to_out) begin failures++; $display("FAIL ones_timeout got=%0d/%0d exp=0/0", to_in, to_out); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (got_s[k] !== 34'sd10) begin failures++; $display("FAIL ones_data[%0d] got=%0d exp=10", k, got_s[k]); end
      checks++; if (last_s[k] !== (k == 3)) begin failures++; $display("FAIL ones_tlast[%0d] got=%b exp=%b", k, last_s[k], k == 3); end
    end
    checks++; if (sb.busy !== 1'b0) begin failures++; $display("FAIL ones_busy_after got=%b exp=0", sb.busy); end
    checks++; if (sb.m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL ones_tvalid_after got=%b exp=0", sb.m_axis_tvalid); end
  endtask

  task automatic test_relu();
    bit to_in, to_out;
    int se;
    int exp_v[4];
    exp_v = '{0, 10, 10, 10};
    for (int i = 0; i < 4; i++) wr_s(0, 0, i, -1);
    vec_s = '{1, 2, 3, 4};
    send_s(1'b0, to_in);
    recv_s(1'b0, to_out, se);
    checks++; if (to_in || to_out) begin failures++; $display("FAIL relu_timeout got=%0d/%0d exp=0/0", to_in, to_out); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (got_s[k] !== 34'(exp_v[k])) begin failures++; $display("FAIL relu_data[%0d] got=%0d exp=%0d", k, got_s[k], exp_v[k]); end
    end
  endtask

  task automatic test_trunc();
    bit to_in, to_out;
    int se;
    for (int h = 0; h < 4; h++) for (int i = 0; i < 4; i++) wr_s(0, h, i, 1000);
    // layer 1 does not exist here; these writes must not alias onto layer 0
    for (int h = 0; h < 4; h++) for (int i = 0; i < 4; i++) wr_s(1, h, i, 0);
    vec_s = '{10, 20, 30, 10};
    send_s(1'b0, to_in);
    recv_s(1'b0, to_out, se);
    checks++; if (to_in || to_out) begin failures++; $display("FAIL trunc_timeout got=%0d/%0d exp=0/0", to_in, to_out); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (got_s[k] !== 34'sd4464) begin failures++; $display("FAIL trunc_data[%0d] got=%0d exp=4464", k, got_s[k]); end
    end
  endtask

  task automatic test_back_to_back();
    bit to_in, to_out;
    int se;
    for (int h = 0; h < 4; h++) for (int i = 0; i < 4; i++) wr_s(0, h, i, h + 1);
    for (int r = 0; r < 2; r++) begin
      vec_s = (r == 0) ? '{1, 2, 3, 4} : '{4, 3, 2, 1};
      send_s(1'b1, to_in);
      recv_s(1'b1, to_out, se);
      checks++; if (to_in || to_out) begin failures++; $display("FAIL bp_timeout[%0d] got=%0d/%0d exp=0/0", r, to_in, to_out); end
      checks++; if (se != 0) begin failures++; $display("FAIL bp_stall_stable[%0d] got=%0d exp=0", r, se); end
      for (int k = 0; k < 4; k++) begin
        checks++; if (got_s[k] !== 34'(10 * (k + 1))) begin failures++; $display("FAIL bp_data[%0d][%0d] got=%0d exp=%0d", r, k, got_s[k], 10 * (k + 1)); end
        checks++; if (last_s[k] !== (k == 3)) begin failures++; $display("FAIL bp_tlast[%0d][%0d] got=%b exp=%b", r, k, last_s[k], k == 3); end
      end
    end
  endtask

  task automatic test_reset_abort();
    bit to_in, to_out;
    int se;
    for (int h = 0; h < 4; h++) for (int i = 0; i < 4; i++) wr_s(0, h, i, 1);
    vec_s = '{1, 2, 3, 4};
    send_s(1'b0, to_in);
    repeat (5) clk_step();
    checks++; if (sb.busy !== 1'b1) begin failures++; $display("FAIL abort_busy_mid got=%b exp=1", sb.busy); end
    wr_s(0, 0, 0, 50);
    repeat (3) clk_step();
    rst_s = 1'b1;
    #1;
    checks++; if (sb.busy !== 1'b0) begin failures++; $display("FAIL abort_busy_rst got=%b exp=0", sb.busy); end
    checks++; if (sb.s_axis_tready !== 1'b0) begin failures++; $display("FAIL abort_tready_rst got=%b exp=0", sb.s_axis_tready); end
    clk_step();
    rst_s = 1'b0;
    sb.m_axis_tready = 1'b1;
    repeat (150) begin
      clk_step();
      if (sb.m_axis_tvalid !== 1'b0) break;
    end
    checks++; if (sb.m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL abort_stale_out got=%b exp=0", sb.m_axis_tvalid); end
    sb.m_axis_tready = 1'b0;
    vec_s = '{4, 3, 2, 1};
    send_s(1'b0, to_in);
    recv_s(1'b0, to_out, se);
    checks++; if (to_in || to_out) begin failures++; $display("FAIL abort_timeout got=%0d/%0d exp=0/0", to_in, to_out); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (got_s[k] !== 34'sd10) begin failures++; $display("FAIL abort_data[%0d] got=%0d exp=10", k, got_s[k]); end
    end
  endtask

  task automatic test_multilayer();
    longint a[16];
    longint y[8];
    longint acc;
    logic [15:0] w16, t16;
    logic signed [35:0] got_m [8];
    logic gl [8];
    int n, cyc;
    bit ok, to_in;
    for (int l = 0; l < 3; l++) for (int h = 0; h < 8; h++) for (int i = 0; i < 16; i++) begin
      mb.w_wr_en = 1'b1; mb.w_addr_l = 2'(l); mb.w_addr_h = 3'(h); mb.w_addr_i = 4'(i);
      mb.w_data = 16'(l * 1000 + h * 10 + i);
      clk_step();
    end
    mb.w_wr_en = 1'b0;
    for (int i = 0; i < 16; i++) a[i] = i;
    for (int l = 0; l < 3; l++) begin
      for (int h = 0; h < 8; h++) begin
        acc = 0;
        for (int i = 0; i < 16; i++) begin
          w16 = 16'(l * 1000 + h * 10 + i);
          acc += longint'($signed(w16)) * a[i];
        end
        t16 = acc[15:0];
        y[h] = (acc < 0) ? 0 : longint'($signed(t16));
      end
      for (int i = 0; i < 16; i++) a[i] = (i < 8) ? y[i] : 0;
    end
    n = 0; to_in = 1'b0;
    for (int k = 0; k < 16; k++) begin
      mb.s_axis_tvalid = 1'b1; mb.s_axis_tdata = 16'(k); mb.s_axis_tlast = (k == 15);
      ok = 1'b0;
      while (!ok && n < 100) begin ok = mb.s_axis_tready; clk_step(); n++; end
      if (!ok) to_in = 1'b1;
    end
    mb.s_axis_tvalid = 1'b0; mb.s_axis_tlast = 1'b0;
    mb.m_axis_tready = 1'b1;
    n = 0; cyc = 0;
    while (n < 8 && cyc < 5000) begin
      if (mb.m_axis_tvalid) begin got_m[n] = mb.m_axis_tdata; gl[n] = mb.m_axis_tlast; n++; end
      clk_step();
      cyc++;
    end
    mb.m_axis_tready = 1'b0;
    checks++; if (to_in || n != 8) begin failures++; $display("FAIL ml_timeout got_in=%0d beats=%0d exp=0/8", to_in, n); end
    for (int h = 0; h < n; h++) begin
      checks++; if (got_m[h] !== 36'(y[h])) begin failures++; $display("FAIL ml_data[%0d] got=%0d exp=%0d", h, got_m[h], y[h]); end
      checks++; if (gl[h] !== (h == 7)) begin failures++; $display("FAIL ml_tlast[%0d] got=%b exp=%b", h, gl[h], h == 7); end
    end
    checks++; if (mb.busy !== 1'b0) begin failures++; $display("FAIL ml_busy_after got=%b exp=0", mb.busy); end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_relu();
    test_trunc();
    test_back_to_back();
    test_reset_abort();
    test_multilayer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bitserial_nn.md
Name: bitserial_nn

Overview:
- Multi-layer fully-connected neural-network inference engine built from P bit-serial multiply-accumulate lanes.
- Accepts an N_IN-element signed input vector over AXI-Stream and evaluates N_LAYERS layers of N_HIDDEN ReLU neurons, using weights held in an internal RAM written through a simple port.
- Emits the final layer's N_HIDDEN activations as an AXI-Stream packet.

Parameters:
- DATA_W, 16: width of inputs, weights and activations (signed).
- PRECISION, 16: weight bits processed serially per MAC (must equal DATA_W).
- N_IN, 256: input vector length; also the per-neuron fan-in of every layer.
- N_HIDDEN, 128: neurons per layer.
- N_LAYERS, 3: number of layers.
- P, 4: parallel neuron lanes; N_HIDDEN must be a multiple of P.
- ACC_W (derived localparam): 2*DATA_W + clog2(max(N_IN,2)) = 40.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  DATA_W  signed input element.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  last input element (informational; the count governs).
- w_wr_en  in  1  weight write strobe.
- w_addr_h  in  clog2(N_HIDDEN)  neuron index.
- w_addr_i  in  clog2(N_IN)  input index.
- w_addr_l  in  clog2(N_LAYERS)  layer index.
- w_data  in  DATA_W  signed weight.
- m_axis_tdata  out  ACC_W  signed output activation.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  high on the last (N_HIDDEN-th) output beat.
- busy  out  1  inference in progress.

Behaviour:
- Reset values: s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, FSM=IDLE. Weight RAM contents are not cleared.
- Weight RAM:
  - On w_wr_en while busy=0, W[l][h][i] <= w_data, one write per cycle.
  - Writes while busy=1 are ignored.
  - Out-of-range l or h addresses are ignored.
- FSM states: IDLE -> LOAD -> COMPUTE -> OUTPUT -> IDLE.
- IDLE: s_axis_tready=1. The first accepted beat stores act[0] and moves to LOAD; busy rises the same cycle.
- LOAD:
  - s_axis_tready=1; beats are accepted on tvalid&&tready and stored as act[i], i=0..N_IN-1.
  - After the N_IN-th beat, tready drops and the FSM enters COMPUTE at layer 0.
  - s_axis_tlast is not checked.
- COMPUTE:
  - For each layer, neurons are processed in groups of P (group g covers h=g*P..g*P+P-1).
  - For each input i, each lane performs a bit-serial MAC over PRECISION cycles. Weight bit b is consumed LSB first; sign-extended act[i]<<b is added to the ACC_W accumulator, except bit PRECISION-1, which is subtracted (two's-complement weight).
  - Layer input: layer 0 uses the streamed vector. Layer l>0 uses the previous layer's activations at i<N_HIDDEN and 0 at i>=N_HIDDEN.
  - Activation rule: if the accumulator is negative, the result is 0. Otherwise the result is acc[DATA_W-1:0], reinterpreted as signed DATA_W (wraps, may read negative).
  - Results go to the next-activation buffer; buffers ping-pong between layers.
  - Cycles per layer are approximately (N_HIDDEN/P)*N_IN*PRECISION, with a constant overhead of no more than 4 cycles per group. The whole inference must complete in under 1,000,000 cycles at default parameters.
- OUTPUT:
  - Beats h=0..N_HIDDEN-1 of the final layer are presented in order.
  - m_axis_tdata is the DATA_W activation sign-extended to ACC_W.
  - Standard AXI rules: data and valid are held stable until tready is seen; tlast is set on h=N_HIDDEN-1.
  - After the last handshake: tvalid=0, busy=0, FSM=IDLE, ready for a new vector.
- Arithmetic: full-precision accumulation in ACC_W with no saturation.
- Reset mid-operation aborts immediately: outputs return to their reset values and partial results are discarded.

Test Plan:
- Config N_IN=4, N_HIDDEN=4, N_LAYERS=1, P=2; all W=1; inputs 1,2,3,4 -> 4 outputs of 10, tlast on the 4th, then busy=0.
- Same config, W[0][h][i]=-1 for h=0, +1 otherwise; inputs 1,2,3,4 -> outputs 0,10,10,10 (ReLU).
- Same config, W=1000; inputs 10,20,30,10 -> acc=70000 -> output 4464 (truncation).
- Defaults: W[l][h][i]=l*1000+h*10+i truncated to 16 bits, inputs x_i=i -> 128 outputs match a bit-accurate model of the layer and activation rules above, within 1,000,000 cycles.
- Backpressure: toggle m_axis_tready every other cycle -> same data, no drops or duplicates, tdata stable while stalled; input tvalid gaps are tolerated.
- Assert rst during COMPUTE, then send a new vector -> no stale output; the correct result is produced; weight writes during busy have no effect.
